mont_mult: RTL and testbench
============================

MONT_MULT -- requirements
Module: mont_mult

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_sig  input  1  start pulse; sampled only in IDLE.
- A_i  input  32  multiplicand, Montgomery domain.
- B_i  input  32  multiplier, Montgomery domain.
- Prime  input  32  odd modulus; held stable from capture until done.
- R_out  output  32  result A*B*2^-32 mod Prime.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion strobe.
REQ-002 The block SHALL use one clock (clk) and a synchronous, active-high reset (reset).

Function
REQ-003 The block SHALL run a four-state FSM: IDLE, CALC, FINAL, OUT.
REQ-004 In IDLE with in_sig=1, the block SHALL capture A_i and B_i on the clock edge, clear the accumulator S and the bit counter, and go to CALC.
REQ-005 In IDLE with in_sig=0, the block SHALL hold all registers, including R_out.
REQ-006 In CALC, on each edge, the block SHALL compute T = S + (A[cnt] ? B : 0); T = T + (T[0] ? Prime : 0); S = T >> 1; then increment cnt.
REQ-007 S and T SHALL be 34 bits wide so that no carry is lost for any 32-bit Prime.
REQ-008 The block SHALL leave CALC for FINAL on the edge that processes cnt=31, so CALC lasts exactly 32 cycles.
REQ-009 In FINAL, the block SHALL load R_out with S - Prime if S >= Prime, otherwise with S[31:0], and go to OUT.
REQ-010 In OUT, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-011 Latency SHALL be fixed: done is high in the 34th cycle after the capture edge.
REQ-012 A new capture is possible on the edge that leaves OUT+1, i.e. the first IDLE cycle.
REQ-013 in_sig asserted in CALC, FINAL or OUT SHALL be ignored and SHALL NOT restart or extend the operation.
REQ-014 Changes on A_i, B_i or Prime after capture SHALL NOT affect the operation in flight, provided Prime is held stable.
REQ-015 R_out SHALL hold its value from FINAL until the next FINAL.
REQ-016 For captured operands < Prime, R_out SHALL be < Prime.
REQ-017 With an even Prime, R_out is unspecified, but the FSM SHALL still complete with done at the same latency.
REQ-018 Operands of 0 SHALL yield R_out = 0.

Reset
REQ-019 When reset=1 at a clock edge, the FSM SHALL go to IDLE and S, cnt, the captured A and B, and R_out SHALL become 0.
REQ-020 After reset, done and busy SHALL be 0, including when reset arrives mid-operation.
REQ-021 An operation aborted by reset SHALL NOT produce done.
REQ-022 Reset SHALL take priority over in_sig.

Configuration
REQ-023 Macro MONT_MULT_INPUT_REDUCE_EN SHALL control input reduction at capture.
REQ-024 With MONT_MULT_INPUT_REDUCE_EN defined, each operand SHALL be reduced at capture by one conditional subtraction: X >= Prime ? X - Prime : X. This adds no latency.
REQ-025 Without MONT_MULT_INPUT_REDUCE_EN, operands SHALL be captured unchanged. The caller guarantees A_i, B_i < Prime, and the output for operands >= Prime is unspecified.

Verification
REQ-026 Prime=13, A_i=5, B_i=7, in_sig pulse -> done exactly 34 cycles later, R_out=1.
REQ-027 Prime=0xFFFFFFFB, A_i=1, B_i=5 -> R_out=1; A_i=0, B_i=0xFFFFFFFA -> R_out=0. Confirms no carry loss at 32-bit Prime.
REQ-028 Prime=13, A_i=5, B_i=7, with in_sig held high through the whole operation -> a single done; a second operation starts only from IDLE; R_out=1 both times.
REQ-029 reset=1 at cycle 10 of CALC -> next cycle busy=0, R_out=0, no done; then A_i=1, B_i=9, Prime=13 -> R_out=1.
REQ-030 With MONT_MULT_INPUT_REDUCE_EN defined: Prime=13, A_i=18, B_i=7 -> R_out=1.
REQ-031 Without MONT_MULT_INPUT_REDUCE_EN: a random sweep of odd Prime and operands < Prime, checked against a reference model -> results match.

Source files
------------

// File: rtl/mont_mult.sv
// Bit-serial Montgomery multiplier: R_out = A*B*2^-32 mod Prime, fixed 34-cycle latency.
// Optional macro MONT_MULT_INPUT_REDUCE_EN reduces each operand once at capture.
module mont_mult (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_sig,
    input  logic [31:0] A_i,
    input  logic [31:0] B_i,
    input  logic [31:0] Prime,
    output logic [31:0] R_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] a_q, b_q;
    logic [33:0] s_q;
    logic [4:0]  cnt_q;
    logic [31:0] a_cap, b_cap;
    logic [33:0] t_add, t_red;

    function automatic logic [31:0] reduce_once(input logic [31:0] x, input logic [31:0] p);
        return (x >= p) ? (x - p) : x;
    endfunction

    // S < 2*Prime after the loop, so a single conditional subtraction completes the reduction.
    function automatic logic [31:0] final_sub(input logic [33:0] s, input logic [31:0] p);
        logic [33:0] d;
        d = s - {2'b00, p};
        return (s >= {2'b00, p}) ? d[31:0] : s[31:0];
    endfunction

`ifdef MONT_MULT_INPUT_REDUCE_EN
    assign a_cap = reduce_once(A_i, Prime);
    assign b_cap = reduce_once(B_i, Prime);
`else
    assign a_cap = A_i;
    assign b_cap = B_i;
`endif

    // 34-bit sum: S + B + Prime stays below 2^34 for any 32-bit Prime.
    always_comb begin
        t_add = s_q + (a_q[cnt_q] ? {2'b00, b_q} : 34'd0);
        t_red = t_add + (t_add[0] ? {2'b00, Prime} : 34'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_sig) state_nxt = CALC;
            CALC:    if (cnt_q == 5'd31) state_nxt = FINAL;
            FINAL:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == OUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            s_q   <= 34'd0;
            cnt_q <= 5'd0;
            R_out <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_sig) begin
                        a_q   <= a_cap;
                        b_q   <= b_cap;
                        s_q   <= 34'd0;
                        cnt_q <= 5'd0;
                    end
                end
                CALC: begin
                    s_q   <= {1'b0, t_red[33:1]};
                    cnt_q <= cnt_q + 5'd1;
                end
                FINAL: begin
                    R_out <= final_sub(s_q, Prime);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mult.sv
// Scoreboard bench for mont_mult: driver pushes expected results, monitor checks on done.
module tb_mont_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_sig;
    logic [31:0] A_i, B_i, Prime;
    logic [31:0] R_out;
    logic        busy, done;

    typedef struct {
        logic [31:0] r;
        int          cyc;
        bit          chk_r;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_done  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mont_mult dut (
        .clk   (clk),
        .reset (reset),
        .in_sig(in_sig),
        .A_i   (A_i),
        .B_i   (B_i),
        .Prime (Prime),
        .R_out (R_out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A*B*2^-32 mod p: reduce the product, then multiply by 2^-1 = (p+1)/2 thirty-two times.
    function automatic logic [31:0] ref_mont(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] p);
        logic [63:0] x, h, pp;
        pp = {32'd0, p};
        x  = ({32'd0, a} * {32'd0, b}) % pp;
        h  = (pp + 64'd1) >> 1;
        for (int i = 0; i < 32; i++) x = (x * h) % pp;
        return x[31:0];
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_latency", cyc, e.cyc);
                if (e.chk_r) check("r_out", R_out, e.r);
            end
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 80 && n_done < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (n_done < target) check("done_timeout", n_done, target);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                          input logic [31:0] exp, input bit chk);
        int target;
        @(negedge clk);
        A_i = a; B_i = b; Prime = p; in_sig = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{exp, cyc + 33, chk});
        in_sig = 1'b0;
        A_i = $urandom;
        B_i = $urandom;
        check("busy_after_capture", busy, 1);
        target = n_done + 1;
        wait_done(target);
    endtask

    initial begin
        int e, nd;
        logic [31:0] p, a, b, last_r;

        reset = 1'b1; in_sig = 1'b0; A_i = '0; B_i = '0; Prime = 32'd13;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_r_out", R_out, 0);

        run_op(32'd5, 32'd7, 32'd13, 32'd1, 1);
        run_op(32'd1, 32'd5, 32'hFFFFFFFB, 32'd1, 1);
        run_op(32'd0, 32'hFFFFFFFA, 32'hFFFFFFFB, 32'd0, 1);
        run_op(32'd0, 32'd0, 32'd13, 32'd0, 1);

        // in_sig held high: one done, then a fresh capture from the first IDLE cycle
        nd = n_done;
        @(negedge clk);
        A_i = 32'd5; B_i = 32'd7; Prime = 32'd13; in_sig = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        sb.push_back('{32'd1, e + 33, 1'b1});
        sb.push_back('{32'd1, e + 68, 1'b1});
        while (cyc < e + 34) @(negedge clk);
        check("hold_single_done", n_done, nd + 1);
        check("hold_idle_gap_busy", busy, 0);
        @(posedge clk);
        #1;
        in_sig = 1'b0;
        check("hold_recapture_busy", busy, 1);
        wait_done(nd + 2);

        // reset in the 10th CALC cycle aborts without done
        @(negedge clk);
        A_i = 32'd5; B_i = 32'd7; Prime = 32'd13; in_sig = 1'b1;
        @(posedge clk);
        #1;
        in_sig = 1'b0;
        sb.push_back('{32'd1, cyc + 33, 1'b1});
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_r_out", R_out, 0);
        void'(sb.pop_back());
        nd = n_done;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", n_done, nd);
        run_op(32'd1, 32'd9, 32'd13, 32'd1, 1);

        // even modulus: result unspecified, latency still fixed
        run_op(32'd3, 32'd5, 32'd16, 32'd0, 0);

`ifdef MONT_MULT_INPUT_REDUCE_EN
        run_op(32'd18, 32'd7, 32'd13, 32'd1, 1);
`endif

        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) p = 32'hFFFFFFFF - ($urandom_range(0, 1000) << 1);
            else            p = $urandom | 32'd1;
            if (p < 32'd3) p = 32'd3;
            if (i == 5) begin
                a = p - 32'd1; b = p - 32'd1;
            end else begin
                a = $urandom % p; b = $urandom % p;
            end
            run_op(a, b, p, ref_mont(a, b, p), 1);
        end

        last_r = R_out;
        repeat (5) @(negedge clk);
        check("r_out_hold_idle", R_out, last_r);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
